stream_demux_sched: RTL and testbench
=====================================

STREAM_DEMUX_SCHED -- requirements
Module: stream_demux_sched

Interface
REQ-001 Parameter S, default 2, select width; the block serves 2**S output channels.
REQ-002 Parameter T, default 8, data word width in bits.
REQ-003 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 Port in_valid, input, 1, upstream word valid.
REQ-006 Port in_ready, output, 1, block accepts the word this cycle.
REQ-007 Port in_data, input, T, upstream word.
REQ-008 Port in_dest, input, S, destination channel, used only in directed mode.
REQ-009 Port mode, input, 1, 0 = round-robin, 1 = directed; sampled only at accept.
REQ-010 Port out_valid, output, 2**S, per-channel valid, at most one bit set.
REQ-011 Port out_ready, input, 2**S, per-channel ready.
REQ-012 Port out_data, output, (2**S)*T, channel k occupies bits [(k+1)*T-1 : k*T].
REQ-013 Port cur_sel, output, S, channel currently held; 0 when idle.

Function
REQ-014 FSM states: IDLE (holding register empty) and HOLD (one word held for channel sel).
REQ-015 Accept = in_valid & in_ready.
REQ-016 in_ready = 1 in IDLE; in HOLD, in_ready = out_ready[sel] (pass-through, one word per cycle); 0 while rst is high.
REQ-017 On accept: data_r <= in_data; sel <= (mode ? in_dest : rr_ptr); state <= HOLD.
REQ-018 Latency: word accepted in cycle n appears on out_valid/out_data in cycle n+1.
REQ-019 In HOLD: out_valid = one-hot(sel); out_data slot sel = data_r; all other slots = 0.
REQ-020 Delivery = HOLD & out_ready[sel]; out_ready bits of other channels have no effect.
REQ-021 Delivery without accept: state <= IDLE, out_valid <= 0 next cycle.
REQ-022 Delivery and accept in the same cycle: state stays HOLD with the new data and sel; no bubble.
REQ-023 rr_ptr increments by 1 modulo 2**S on each accept made in round-robin mode; wrap 2**S-1 -> 0; directed accepts leave rr_ptr unchanged.
REQ-024 A change of mode or in_dest while in HOLD does not alter the held sel.
REQ-025 in_valid with in_ready low: no state change; upstream holds the word.
REQ-026 In IDLE: out_valid = 0 and out_data = 0.

Reset
REQ-027 While rst is high at a clock edge: state <= IDLE, rr_ptr <= 0, sel <= 0, data_r <= 0.
REQ-028 After reset: out_valid = 0, out_data = 0, cur_sel = 0; in_ready = 1 from the first cycle after rst deasserts.
REQ-029 Reset during HOLD discards the held word; no out_valid is raised for it afterward.

Structure
REQ-030 Shared package: state encoding (IDLE, HOLD) and mode constants (MODE_RR = 0, MODE_DIR = 1).
REQ-031 out_data fan-out is one instance of the team's recursive demux sub-module recurse_demux, parameters S and T, with ctrl = sel and in = data_r, gated to zero in IDLE.
REQ-032 out_valid is produced by a second recurse_demux instance with T = 1 and in = (state == HOLD).

Verification
REQ-033 S=2, T=8, mode=0, out_ready=4'b1111: send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> delivered on channels 0, 1, 2, 3, 0; one word per cycle, first out_valid one cycle after the first accept.
REQ-034 mode=1, in_dest=2, data 0xA5, out_ready=0 for 3 cycles then 4'b0100 -> out_valid=4'b0100 held with out_data[23:16]=0xA5 and in_ready=0 for 3 cycles; word delivered in cycle 4; in_ready returns to 1.
REQ-035 HOLD on channel 1, out_ready=4'b1101 (channel 1 not ready) -> no delivery, in_ready=0; other channels' out_valid stay 0.
REQ-036 Alternate mode 0 and mode 1 (in_dest=3) across 4 accepts -> round-robin channels 0, 1 with rr_ptr=2 at the end; directed words go to channel 3.
REQ-037 rst asserted during HOLD with data 0x7E -> next cycle out_valid=0, cur_sel=0, in_ready=1 after deassert; 0x7E never delivered.
REQ-038 Continuous checks on every cycle: out_valid has at most one bit set; every non-selected out_data slot is 0.

Source files
------------

// File: rtl/stream_demux_sched_pkg.sv
// Shared definitions for the stream demultiplexer/scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stream_demux_sched_pkg;

    // The holding register is either empty or holds one word for channel sel.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Values of the mode input.
    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

endpackage

// File: rtl/stream_demux_sched_recurse_demux.sv
// Recursive 1-to-2**S demux: routes 'in' to slot 'ctrl' of 'out', all other slots zero.
// Latency: purely combinational.
// Backpressure: none; no handshake of its own.
// Ports: ctrl [S-1:0] slot select; in [T-1:0] word; out [(2**S)*T-1:0], slot k at [(k+1)*T-1:k*T].
module recurse_demux #(
    parameter int S = 2,
    parameter int T = 8
) (
    input  logic [S-1:0]         ctrl,
    input  logic [T-1:0]         in,
    output logic [(2**S)*T-1:0]  out
);

    generate
        if (S == 1) begin : g_leaf
            assign out = ctrl[0] ? {in, {T{1'b0}}} : {{T{1'b0}}, in};
        end else begin : g_node
            localparam int HALF = (2**(S-1))*T;
            logic [T-1:0] in_lo;
            logic [T-1:0] in_hi;

            // The top select bit picks the half; the lower bits pick within it.
            assign in_lo = ctrl[S-1] ? '0 : in;
            assign in_hi = ctrl[S-1] ? in : '0;

            recurse_demux #(.S(S-1), .T(T)) u_lo (
                .ctrl (ctrl[S-2:0]),
                .in   (in_lo),
                .out  (out[HALF-1:0])
            );

            recurse_demux #(.S(S-1), .T(T)) u_hi (
                .ctrl (ctrl[S-2:0]),
                .in   (in_hi),
                .out  (out[2*HALF-1:HALF])
            );
        end
    endgenerate

endmodule

// File: rtl/stream_demux_sched.sv
// Stream demux: one input stream steered to 2**S channels, round-robin or by in_dest.
// Latency: one cycle from accept to out_valid; full throughput of one word per cycle.
// Backpressure: in_ready follows out_ready of the held channel; other channels' ready ignored.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_data/in_dest/mode upstream;
//        out_valid/out_ready per channel, out_data packed slots; cur_sel = held channel (0 when idle).
module stream_demux_sched
    import stream_demux_sched_pkg::*;
#(
    parameter int S = 2,
    parameter int T = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [T-1:0]         in_data,
    input  logic [S-1:0]         in_dest,
    input  logic                 mode,
    output logic [(2**S)-1:0]    out_valid,
    input  logic [(2**S)-1:0]    out_ready,
    output logic [(2**S)*T-1:0]  out_data,
    output logic [S-1:0]         cur_sel
);

    state_t         state, state_nxt;
    logic [S-1:0]   sel, sel_nxt;
    logic [S-1:0]   rr_ptr, rr_nxt;
    logic [T-1:0]   data_r, data_nxt;
    logic           held;
    logic           accept;
    logic           deliver;
    logic [T-1:0]   data_gated;

    assign held     = (state == HOLD);
    // A held word frees its slot in the same cycle it is delivered, so a new
    // word can be taken alongside it without a bubble.
    assign in_ready = !rst && (!held || out_ready[sel]);
    assign accept   = in_valid && in_ready;
    assign deliver  = held && out_ready[sel];

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        data_nxt  = data_r;
        if (accept) begin
            state_nxt = HOLD;
            data_nxt  = in_data;
            sel_nxt   = (mode == MODE_DIR) ? in_dest : rr_ptr;
            if (mode == MODE_RR) begin
                rr_nxt = rr_ptr + S'(1);
            end
        end else if (deliver) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
            data_r <= '0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            rr_ptr <= rr_nxt;
            data_r <= data_nxt;
        end
    end

    // Stale data_r after delivery must not leak onto the bus while idle.
    assign data_gated = held ? data_r : '0;
    assign cur_sel    = held ? sel : '0;

    recurse_demux #(.S(S), .T(T)) u_data_demux (
        .ctrl (sel),
        .in   (data_gated),
        .out  (out_data)
    );

    recurse_demux #(.S(S), .T(1)) u_valid_demux (
        .ctrl (sel),
        .in   (held),
        .out  (out_valid)
    );

endmodule

// File: tb/tb_stream_demux_sched.sv
module tb_stream_demux_sched;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_dest;
    logic        mode;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  cur_sel;

    int checks = 0;
    int errors = 0;

    stream_demux_sched #(.S(2), .T(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cur_sel   (cur_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a capacity-one queue of (channel, word) pairs plus the
    // round-robin counter, stepped once per clock from the handshake rules.
    int unsigned q_ch[$];
    logic [7:0]  q_dat[$];
    int unsigned rr_cnt = 0;

    // Outputs sampled mid-cycle by the last call of cycle().
    logic        s_rdy;
    logic [3:0]  s_vld;
    logic [31:0] s_dat;
    logic [1:0]  s_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drives one cycle of inputs, checks outputs against the model at the
    // falling edge, then advances the model across the rising edge.
    task automatic cycle(input logic r, input logic iv, input logic [7:0] d,
                         input logic [1:0] dst, input logic md, input logic [3:0] ordy);
        logic        full;
        int unsigned ch;
        logic        e_rdy;
        logic [3:0]  e_vld;
        logic [31:0] e_dat;
        rst = r; in_valid = iv; in_data = d; in_dest = dst; mode = md; out_ready = ordy;
        full  = (q_ch.size() != 0);
        ch    = full ? q_ch[0] : 0;
        e_rdy = !r && (!full || ordy[ch]);
        e_vld = full ? (4'b0001 << ch) : 4'b0000;
        e_dat = full ? (32'(q_dat[0]) << (8 * ch)) : 32'h0;
        @(negedge clk);
        s_rdy = in_ready; s_vld = out_valid; s_dat = out_data; s_sel = cur_sel;
        chk("model in_ready", 32'(in_ready), 32'(e_rdy));
        chk("model out_valid", 32'(out_valid), 32'(e_vld));
        chk("model out_data", out_data, e_dat);
        chk("model cur_sel", 32'(cur_sel), ch);
        chk("onehot out_valid", 32'($countones(out_valid) <= 1), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (!out_valid[k]) chk($sformatf("idle slot %0d", k), 32'(out_data[k*8 +: 8]), 32'h0);
        end
        @(posedge clk);
        if (r) begin
            q_ch.delete(); q_dat.delete(); rr_cnt = 0;
        end else begin
            if (full && ordy[ch]) begin
                void'(q_ch.pop_front()); void'(q_dat.pop_front());
            end
            if (iv && e_rdy) begin
                q_ch.push_back(md ? 32'(dst) : rr_cnt);
                q_dat.push_back(d);
                if (!md) rr_cnt = (rr_cnt + 1) % 4;
            end
        end
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        iv;
        logic [7:0]  d;
        logic [1:0]  dst;
        logic        md;
        logic [3:0]  ordy;
        logic        e_rdy;
        logic [3:0]  e_vld;
        logic [31:0] e_dat;
        logic [1:0]  e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic [1:0] dst, logic md,
                                logic [3:0] ordy, logic e_rdy, logic [3:0] e_vld,
                                logic [31:0] e_dat, logic [1:0] e_sel);
        vec_t v;
        v.r = r; v.iv = iv; v.d = d; v.dst = dst; v.md = md; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_sel = e_sel;
        return v;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0; mode = 1'b0; out_ready = '0;
        @(posedge clk);
        #1;

        //           r  iv d      dst md ordy     rdy vld      data          sel
        // reset, then round-robin burst 11..55 at full throughput
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 0, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 1, 8'h22, 0, 0, 4'b1111, 1, 4'b0001, 32'h00000011, 0));
        tbl.push_back(mk(0, 1, 8'h33, 0, 0, 4'b1111, 1, 4'b0010, 32'h00002200, 1));
        tbl.push_back(mk(0, 1, 8'h44, 0, 0, 4'b1111, 1, 4'b0100, 32'h00330000, 2));
        tbl.push_back(mk(0, 1, 8'h55, 0, 0, 4'b1111, 1, 4'b1000, 32'h44000000, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0001, 32'h00000055, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        // directed A5 to channel 2, stalled three cycles
        tbl.push_back(mk(0, 1, 8'hA5, 2, 1, 4'b0000, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 4'b0000, 0, 4'b0100, 32'h00A50000, 2));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 4'b0000, 0, 4'b0100, 32'h00A50000, 2));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 4'b0000, 0, 4'b0100, 32'h00A50000, 2));
        tbl.push_back(mk(0, 0, 8'h00, 2, 1, 4'b0100, 1, 4'b0100, 32'h00A50000, 2));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        // round-robin word to channel 1; other channels ready but 1 is not
        tbl.push_back(mk(0, 1, 8'h3C, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 1, 8'h99, 3, 1, 4'b1101, 0, 4'b0010, 32'h00003C00, 1));
        tbl.push_back(mk(0, 1, 8'h99, 3, 1, 4'b1101, 0, 4'b0010, 32'h00003C00, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0010, 32'h00003C00, 1));
        // reset, then alternate round-robin / directed-to-3
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b1111, 0, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 1, 8'h01, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 1, 8'h02, 3, 1, 4'b1111, 1, 4'b0001, 32'h00000001, 0));
        tbl.push_back(mk(0, 1, 8'h03, 0, 0, 4'b1111, 1, 4'b1000, 32'h02000000, 3));
        tbl.push_back(mk(0, 1, 8'h04, 3, 1, 4'b1111, 1, 4'b0010, 32'h00000300, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b1000, 32'h04000000, 3));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        // next round-robin word shows the pointer stopped at 2
        tbl.push_back(mk(0, 1, 8'h05, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 4'b1111, 1, 4'b0100, 32'h00050000, 2));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        // reset while holding 7E: word is dropped
        tbl.push_back(mk(0, 1, 8'h7E, 1, 1, 4'b0000, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'b0000, 0, 4'b0010, 32'h00007E00, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'b1111, 1, 4'b0000, 32'h00000000, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].dst, tbl[i].md, tbl[i].ordy);
            chk($sformatf("vec%0d in_ready", i), 32'(s_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(s_vld), 32'(tbl[i].e_vld));
            chk($sformatf("vec%0d out_data", i), s_dat, tbl[i].e_dat);
            chk($sformatf("vec%0d cur_sel", i), 32'(s_sel), 32'(tbl[i].e_sel));
        end

        // Randomized traffic with occasional resets, checked against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 3) != 0),
                  8'($urandom),
                  2'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
